sub_divider_ctrl: RTL

Sequential restoring-division controller built around a ripple-borrow subtractor datapath. It accepts an unsigned dividend and divisor on a start pulse. It then steps the subtractor once per cycle, using the borrow-out to decide each quotient bit, and returns quotient and remainder with a done pulse. It sits beside the arithmetic block as the multi-cycle divide unit of the microprocessor datapath.

---
 rtl/sub_divider_ctrl_if.sv | 24 ++
 rtl/sub_divider_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sub_divider_ctrl_if.sv
// Handshake and operand/result bundle for the multi-cycle divide unit.
// The master issues requests; the slave (the divider) returns results.
interface sub_divider_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, quotient, remainder
  );
endinterface

// File: rtl/sub_divider_ctrl.sv
// Sequential restoring divider: one ripple-borrow subtract per cycle, MSB first,
// with quotient/remainder/done loaded together on entry to FIN.
module sub_divider_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  sub_divider_ctrl_if.slave bus
);
  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] v_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] q_r;
  logic [KW-1:0]    k_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;

  logic [WIDTH:0]   t_s;
  logic [WIDTH-1:0] diff_s;
  logic             borrow_s;
  logic [WIDTH-1:0] r_nxt_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic             last_s;
  logic             div0_s;

  // Ripple-borrow subtract a - b; returns {borrow_out, low WIDTH difference bits}.
  // The top difference bit is dropped: when no borrow occurs it is always 0.
  function automatic logic [WIDTH:0] ripple_sub(input logic [WIDTH:0] a,
                                                input logic [WIDTH:0] b);
    logic             bw;
    logic [WIDTH-1:0] d;
    bw = 1'b0;
    d  = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      d[i] = a[i] ^ b[i] ^ bw;
      bw   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
    end
    bw = (~a[WIDTH] & b[WIDTH]) | (~(a[WIDTH] ^ b[WIDTH]) & bw);
    return {bw, d};
  endfunction

  // One restoring-division step plus decode of the loop and zero-divisor conditions.
  always_comb begin
    t_s                  = {r_r, d_r[k_r]};
    {borrow_s, diff_s}   = ripple_sub(t_s, {1'b0, v_r});
    if (borrow_s) begin
      r_nxt_s = t_s[WIDTH-1:0];
    end else begin
      r_nxt_s = diff_s;
    end
    q_nxt_s      = q_r;
    q_nxt_s[k_r] = ~borrow_s;
    last_s       = (k_r == {KW{1'b0}});
    div0_s       = (bus.divisor == {WIDTH{1'b0}});
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = div0_s ? FIN : ITER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ITER: begin
        if (last_s) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = ITER;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand, iteration and result registers; results load on the edge entering FIN
  // so that done, quotient and remainder become visible in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r         <= {WIDTH{1'b0}};
      v_r         <= {WIDTH{1'b0}};
      r_r         <= {WIDTH{1'b0}};
      q_r         <= {WIDTH{1'b0}};
      k_r         <= {KW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div_zero_r  <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            d_r <= bus.dividend;
            v_r <= bus.divisor;
            r_r <= {WIDTH{1'b0}};
            q_r <= {WIDTH{1'b0}};
            k_r <= KW'(WIDTH - 1);
            if (div0_s) begin
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              div_zero_r  <= 1'b1;
              quotient_r  <= {WIDTH{1'b1}};
              remainder_r <= bus.dividend;
            end else begin
              busy_r     <= 1'b1;
              div_zero_r <= 1'b0;
            end
          end
        end
        ITER: begin
          r_r <= r_nxt_s;
          q_r <= q_nxt_s;
          k_r <= k_r - KW'(1);
          if (last_s) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            quotient_r  <= q_nxt_s;
            remainder_r <= r_nxt_s;
          end
        end
        FIN: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.div_zero  = div_zero_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
endmodule
